// File: rtl/drec_sdram_port.sv
// drec_sdram_port: SDRAM-side responder for the recorder controller.
// Queues single-cycle write/read strobes in order, issues them one at a time on a
// valid/ready memory port, and returns read data as a one-cycle rdy pulse.
// Optional build macro: DREC_SDRAM_PORT_ACKCHK_EN -- a missing ack in ACK sets err.
module drec_sdram_port #(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sdram_wr_data,
    input  logic [ADDR_W-1:0] sdram_wr_addr,
    input  logic              sdram_wr_enable,
    input  logic [ADDR_W-1:0] sdram_rd_addr,
    input  logic              sdram_rd_enable,
    output logic [DATA_W-1:0] sdram_rd_data,
    output logic              sdram_rd_data_rdy,
    input  logic              sdram_rd_data_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ovf,
    output logic              err
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = LW + 1;
    localparam int unsigned FW = PW + 1;
    localparam int unsigned EW = 1 + ADDR_W + DATA_W;
    localparam int unsigned TW = $clog2(RD_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RESP    = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [EW-1:0]     fifo_q [FIFO_DEPTH];
    logic [EW-1:0]     fifo_d [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rdy_q, rdy_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic              empty_c, pop_c, wr_ok_c, rd_ok_c;
    logic [PW-1:0]     count_c, rd_slot_c;
    logic [FW-1:0]     free_c;
    logic [EW-1:0]     head_c;
    logic              timeout_c, ack_miss_c;

    // Queue occupancy; a pop in the same cycle frees its slot for a push
    always_comb begin
        empty_c   = (wptr_q == rptr_q);
        count_c   = PW'(wptr_q - rptr_q);
        pop_c     = (state_q == S_IDLE) && !empty_c;
        free_c    = FW'(FIFO_DEPTH) - FW'(count_c) + FW'(pop_c);
        head_c    = fifo_q[rptr_q[LW-1:0]];
        timeout_c = (timer_q == TW'(RD_TIMEOUT - 1));
    end

`ifdef DREC_SDRAM_PORT_ACKCHK_EN
    assign ack_miss_c = !sdram_rd_data_ack;
`else
    logic unused_ack;
    assign unused_ack = sdram_rd_data_ack;
    assign ack_miss_c = 1'b0;
`endif

    // Enqueue: write first, then read; drops set sticky ovf, entries never overwritten
    always_comb begin
        fifo_d    = fifo_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ovf_d     = ovf_q;
        wr_ok_c   = 1'b0;
        rd_ok_c   = 1'b0;
        rd_slot_c = wptr_q;
        if (pop_c) begin
            rptr_d = PW'(rptr_q + PW'(1));
        end
        if (sdram_wr_enable && (free_c >= FW'(1))) begin
            wr_ok_c = 1'b1;
            fifo_d[wptr_q[LW-1:0]] = {1'b1, sdram_wr_addr, sdram_wr_data};
        end
        if (sdram_rd_enable) begin
            rd_ok_c = sdram_wr_enable ? (free_c >= FW'(2)) : (free_c >= FW'(1));
        end
        rd_slot_c = PW'(wptr_q + PW'(wr_ok_c));
        if (rd_ok_c) begin
            fifo_d[rd_slot_c[LW-1:0]] = {1'b0, sdram_rd_addr, DATA_W'(0)};
        end
        wptr_d = PW'(wptr_q + PW'(wr_ok_c) + PW'(rd_ok_c));
        if ((sdram_wr_enable && !wr_ok_c) || (sdram_rd_enable && !rd_ok_c)) begin
            ovf_d = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one op in flight, strictly in order
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!empty_c) state_d = S_REQ;
            S_REQ:     if (mem_gnt) state_d = mem_we_q ? S_IDLE : S_RD_WAIT;
            S_RD_WAIT: if (mem_rvalid || timeout_c) state_d = S_RESP;
            S_RESP:    state_d = S_ACK;
            S_ACK:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered memory-port and response signals
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rdy_d       = 1'b0;
        timer_d     = timer_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (!empty_c) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = head_c[EW-1];
                    mem_addr_d  = head_c[EW-2:DATA_W];
                    mem_wdata_d = head_c[DATA_W-1:0];
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    timer_d   = '0;
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    rd_data_d = mem_rdata;
                    rdy_d     = 1'b1;
                end else if (timeout_c) begin
                    rd_data_d = '0;
                    rdy_d     = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    timer_d = TW'(timer_q + TW'(1));
                end
            end
            S_ACK: begin
                if (ack_miss_c) err_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and queue registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rdy_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            fifo_q      <= fifo_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rdy_q       <= rdy_d;
            timer_q     <= timer_d;
        end
    end

    assign sdram_rd_data     = rd_data_q;
    assign sdram_rd_data_rdy = rdy_q;
    assign mem_req           = mem_req_q;
    assign mem_we            = mem_we_q;
    assign mem_addr          = mem_addr_q;
    assign mem_wdata         = mem_wdata_q;
    assign ovf               = ovf_q;
    assign err               = err_q;

endmodule

// File: tb/tb_drec_sdram_port.sv
// Scoreboard bench for drec_sdram_port: stimulus pushes expected memory requests and
// read responses; a negedge monitor pops and compares as the DUT presents them.
module tb_drec_sdram_port;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        rst_n;
    logic [15:0] wr_data;
    logic [23:0] wr_addr;
    logic        wr_en;
    logic [23:0] rd_addr;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rdy;
    logic        ack;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        ovf;
    logic        err;

    drec_sdram_port #(
        .ADDR_W(24), .DATA_W(16), .FIFO_DEPTH(4), .RD_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sdram_wr_data(wr_data), .sdram_wr_addr(wr_addr), .sdram_wr_enable(wr_en),
        .sdram_rd_addr(rd_addr), .sdram_rd_enable(rd_en),
        .sdram_rd_data(rd_data), .sdram_rd_data_rdy(rdy), .sdram_rd_data_ack(ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ovf(ovf), .err(err)
    );

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [15:0] data;
    } req_t;

    typedef struct packed {
        logic [15:0] data;
        int          lat;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   acc_cyc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rd_acc_cyc = 0;
    int   rv_delay = 0;
    logic [15:0] rv_data = 16'h0;
    logic ack_en = 1'b1;
    logic prev_rdy = 1'b0;
    logic rdy_seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    // Monitor: compare accepted requests and read responses against the scoreboard
    always @(negedge clk) begin
        req_t r;
        rsp_t e;
        if (rst_n) begin
            if (mem_req && mem_gnt) begin
                acc_cyc_q.push_back(cyc);
                if (!mem_we) rd_acc_cyc = cyc;
                checks++;
                if (exp_req.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected: got %h exp none", {mem_we, mem_addr, mem_wdata});
                end else begin
                    r = exp_req.pop_front();
                    if ({mem_we, mem_addr, mem_wdata} !== r) begin
                        errors++;
                        $display("FAIL req_content: got %h exp %h", {mem_we, mem_addr, mem_wdata}, r);
                    end
                end
            end
            if (rdy) begin
                checks++;
                if (prev_rdy) begin
                    errors++;
                    $display("FAIL rdy_width: got 2+ cycles exp 1");
                end
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got %h exp none", rd_data);
                end else begin
                    e = exp_rsp.pop_front();
                    if (rd_data !== e.data || (cyc - rd_acc_cyc) != e.lat) begin
                        errors++;
                        $display("FAIL rsp: got data %h lat %0d exp data %h lat %0d",
                                 rd_data, cyc - rd_acc_cyc, e.data, e.lat);
                    end
                end
            end
        end
        prev_rdy = rdy;
    end

    // Memory core model: one rvalid pulse rv_delay cycles after a read is granted
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req && mem_gnt && !mem_we && rv_delay > 0) begin
                repeat (rv_delay) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = rv_data;
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata  = 16'h0;
            end
        end
    end

    // Controller ack: high the cycle after rdy when enabled
    initial begin
        ack = 1'b0;
        forever begin
            @(negedge clk);
            ack      = ack_en && rdy_seen;
            rdy_seen = rdy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h", name, got, exp);
        end
    endtask

    task automatic exp_w(input logic [23:0] a, input logic [15:0] d);
        req_t r;
        r.we = 1'b1; r.addr = a; r.data = d;
        exp_req.push_back(r);
    endtask

    task automatic exp_r(input logic [23:0] a);
        req_t r;
        r.we = 1'b0; r.addr = a; r.data = 16'h0;
        exp_req.push_back(r);
    endtask

    task automatic exp_d(input logic [15:0] d, input int lat);
        rsp_t e;
        e.data = d; e.lat = lat;
        exp_rsp.push_back(e);
    endtask

    task automatic wr(input logic [23:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [23:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic both(input logic [23:0] wa, input logic [15:0] d, input logic [23:0] ra);
        wr_en = 1'b1; wr_addr = wa; wr_data = d;
        rd_en = 1'b1; rd_addr = ra;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_req.size() == 0 && exp_rsp.size() == 0) break;
            tick();
        end
        check(name, 32'(exp_req.size() + exp_rsp.size()), 32'd0);
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en   = 1'b0; rd_addr = '0;
        mem_gnt = 1'b1;
        repeat (3) tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_flags", 32'({ovf, err}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single write, two-cycle request latency, one-cycle request
        exp_w(24'h000005, 16'h1234);
        wr(24'h000005, 16'h1234);
        check("t1_lat_early", 32'(mem_req), 32'd0);
        tick();
        check("t1_req_high", 32'(mem_req), 32'd1);
        tick();
        check("t1_req_1cyc", 32'(mem_req), 32'd0);
        drain("t1_drain", 20);

        // 2: read with rvalid 3 cycles after grant, acked
        rv_delay = 3; rv_data = 16'hBEEF;
        exp_r(24'h000010);
        exp_d(16'hBEEF, 4);
        rd(24'h000010);
        drain("t2_drain", 40);
        check("t2_flags", 32'({ovf, err}), 32'd0);

        // 3: backpressure, 6 writes with gnt low, 6th dropped
        mem_gnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_w(24'h000100 + 24'(i), 16'h1000 + 16'(i));
            wr(24'h000100 + 24'(i), 16'h1000 + 16'(i));
        end
        check("t3_ovf", 32'(ovf), 32'd1);
        tick();
        acc_cyc_q.delete();
        mem_gnt = 1'b1;
        drain("t3_drain", 60);
        check("t3_count", 32'(acc_cyc_q.size()), 32'd5);
        if (acc_cyc_q.size() == 5) check("t3_thruput", 32'(acc_cyc_q[4] - acc_cyc_q[0]), 32'd8);

        do_reset();
        check("rst2_ovf", 32'(ovf), 32'd0);

        // 4a: simultaneous write+read, write issued first
        rv_delay = 2; rv_data = 16'h5555;
        exp_w(24'h000001, 16'hAAAA);
        exp_r(24'h000002);
        exp_d(16'h5555, 3);
        both(24'h000001, 16'hAAAA, 24'h000002);
        drain("t4a_drain", 40);
        check("t4a_ovf", 32'(ovf), 32'd0);

        // 4b: simultaneous with one free entry drops the read
        do_reset();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_w(24'h000200 + 24'(i), 16'h2000 + 16'(i));
            wr(24'h000200 + 24'(i), 16'h2000 + 16'(i));
        end
        exp_w(24'h000001, 16'hAAAA);
        both(24'h000001, 16'hAAAA, 24'h000002);
        check("t4b_ovf", 32'(ovf), 32'd1);
        mem_gnt = 1'b1;
        drain("t4b_drain", 60);

        // 5: read timeout, next queued write still proceeds
        rv_delay = 0;
        exp_r(24'h000020);
        exp_d(16'h0000, int'(TO) + 1);
        exp_w(24'h000021, 16'h00C3);
        rd(24'h000020);
        wr(24'h000021, 16'h00C3);
        drain("t5_drain", 100);
        check("t5_err", 32'(err), 32'd1);

        // 6: asynchronous reset during RD_WAIT; late rvalid ignored
        rv_delay = 10; rv_data = 16'hDEAD;
        exp_r(24'h000030);
        rd(24'h000030);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", 32'(mem_req), 32'd0);
        check("t6_rst_rdy", 32'(rdy), 32'd0);
        check("t6_rst_flags", 32'({ovf, err}), 32'd0);
        check("t6_rst_addr", 32'(mem_addr), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        check("t6_after", 32'({mem_req, rdy, err}), 32'd0);
        check("t6_queue", 32'(exp_req.size() + exp_rsp.size()), 32'd0);

        // 7: withheld ack
        rv_delay = 1; rv_data = 16'h7777;
        ack_en = 1'b0;
        exp_r(24'h000040);
        exp_d(16'h7777, 2);
        rd(24'h000040);
        drain("t7_drain", 40);
`ifdef DREC_SDRAM_PORT_ACKCHK_EN
        check("t7_err", 32'(err), 32'd1);
`else
        check("t7_err", 32'(err), 32'd0);
`endif
        ack_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
